// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial datapath: sizing constants and the
// evaluator state encoding. The upstream polynomial adder uses them too.
package poly_pkg;

  localparam int NCOEF = 6;   // coefficient slots
  localparam int CW    = 8;   // coefficient / evaluation point width
  localparam int RW    = 16;  // result width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EVAL = 2'd2
  } state_t;

endpackage

// File: rtl/poly_mac.sv
// One Horner step: acc_next = acc * x + c, unsigned.
// Build option POLY_EVAL_SAT_EN: when defined, the product and the sum each
// clamp to all-ones on overflow; otherwise both wrap modulo 2^RW.
module poly_mac #(
  parameter int CW = poly_pkg::CW,
  parameter int RW = poly_pkg::RW
) (
  input  logic [RW-1:0] acc,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] c,
  output logic [RW-1:0] acc_next
);

`ifdef POLY_EVAL_SAT_EN
  logic [RW+CW-1:0] prod_full;
  logic [RW-1:0]    prod_red;
  logic [RW:0]      sum_full;

  // Full-width product, then clamp each stage on carry-out.
  always_comb begin
    prod_full = acc * x;
    prod_red  = (|prod_full[RW+CW-1:RW]) ? '1 : prod_full[RW-1:0];
    sum_full  = {1'b0, prod_red} + (RW+1)'(c);
    acc_next  = sum_full[RW] ? '1 : sum_full[RW-1:0];
  end
`else
  logic [RW-1:0] prod_red;

  // Keeping only the low RW bits of the full product is the same as
  // reducing it modulo 2^RW, so the upper product bits are never built.
  always_comb begin
    prod_red = RW'(acc * x);
    acc_next = prod_red + RW'(c);
  end
`endif

endmodule

// File: rtl/poly_eval.sv
// Polynomial evaluator: collects up to NCOEF coefficients (lowest degree
// first) while in_wr is high, then evaluates them at Xp with Horner's rule,
// one multiply-add per clock. Build option POLY_EVAL_SAT_EN selects
// saturating instead of wrapping arithmetic inside poly_mac.
module poly_eval #(
  parameter int NCOEF = poly_pkg::NCOEF,
  parameter int CW    = poly_pkg::CW,
  parameter int RW    = poly_pkg::RW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          in_wr,
  input  logic [CW-1:0] in_R,
  input  logic [CW-1:0] Xp,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] Y,
  output logic          ovf
);
  import poly_pkg::*;

  localparam int CNTW = $clog2(NCOEF + 1);

  state_t          state_reg;
  logic [CNTW-1:0] count_reg;
  logic [CNTW-1:0] idx_reg;
  logic [RW-1:0]   acc_reg;
  logic [CW-1:0]   x_reg;
  logic [RW-1:0]   y_reg;
  logic            done_reg;
  logic            busy_reg;
  logic            ovf_reg;

  logic [CW-1:0]   coef_mem [NCOEF];
  logic            coef_we;
  logic [CNTW-1:0] wr_addr;
  logic [CW-1:0]   last_coef;
  logic [RW-1:0]   mac_next;

  // Decide whether this edge stores in_R and into which slot. EVAL never
  // writes, so a stray strobe during evaluation cannot disturb the set.
  always_comb begin
    coef_we = 1'b0;
    wr_addr = count_reg;
    if (in_wr) begin
      if (state_reg == IDLE) begin
        coef_we = 1'b1;
        wr_addr = '0;
      end else if (state_reg == LOAD && count_reg < CNTW'(NCOEF)) begin
        coef_we = 1'b1;
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NCOEF; gi++) begin : g_coef
    logic [CW-1:0] slot_reg;

    // Capture the incoming coefficient when this slot is addressed.
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
        slot_reg <= '0;
      else if (coef_we && wr_addr == CNTW'(gi))
        slot_reg <= in_R;
    end

    assign coef_mem[gi] = slot_reg;
  end

  assign last_coef = coef_mem[count_reg - CNTW'(1)];

  poly_mac #(
    .CW (CW),
    .RW (RW)
  ) u_mac (
    .acc      (acc_reg),
    .x        (x_reg),
    .c        (coef_mem[idx_reg]),
    .acc_next (mac_next)
  );

  // Control FSM with registered status outputs; idx walks down to 0.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      acc_reg   <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_wr) begin
            count_reg <= CNTW'(1);
            ovf_reg   <= 1'b0;
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          if (in_wr) begin
            if (count_reg < CNTW'(NCOEF))
              count_reg <= count_reg + CNTW'(1);
            else
              ovf_reg <= 1'b1;
          end else if (count_reg == CNTW'(1)) begin
            // A constant polynomial needs no multiply-add.
            acc_reg   <= RW'(last_coef);
            y_reg     <= RW'(last_coef);
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            x_reg     <= Xp;
            acc_reg   <= RW'(last_coef);
            idx_reg   <= count_reg - CNTW'(2);
            busy_reg  <= 1'b1;
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          acc_reg <= mac_next;
          if (idx_reg == '0) begin
            y_reg     <= mac_next;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            idx_reg <= idx_reg - CNTW'(1);
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign Y    = y_reg;
  assign ovf  = ovf_reg;

endmodule
